// File: rtl/seq_divider.sv
// Switch-driven sequential radix-2 restoring divider.
// A change on sw starts a new division that resolves one quotient bit per clock.
// led shows only the last completed {remainder, quotient}; partial values never reach it.
module seq_divider #(
    parameter int unsigned N   = 8,
    parameter bit          INV = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2*N-1:0]   sw,
    output logic [2*N-1:0]   led,
    output logic             busy,
    output logic             dz
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Registered state
    state_t             r_state;
    logic [N-1:0]       r_a_q;
    logic [N-1:0]       r_b_q;
    logic               r_load;
    logic [N-1:0]       r_d;
    logic [N-1:0]       r_quo;
    logic [N:0]         r_rem;
    logic [CW-1:0]      r_cnt;
    logic [2*N-1:0]     r_result;
    logic               r_busy;
    logic               r_dz;

    // Combinational signals
    logic [N-1:0]       w_dividend;
    logic [N-1:0]       w_divisor;
    logic               w_change;
    logic [N:0]         w_shift;
    logic [N:0]         w_trial;
    logic [N:0]         w_rem_step;
    logic [N-1:0]       w_quo_step;
    state_t             w_state_nx;
    logic [N-1:0]       w_d_nx;
    logic [N-1:0]       w_quo_nx;
    logic [N:0]         w_rem_nx;
    logic [CW-1:0]      w_cnt_nx;
    logic [2*N-1:0]     w_result_nx;
    logic               w_busy_nx;
    logic               w_dz_nx;

    assign w_dividend = sw[N-1:0];
    assign w_divisor  = sw[2*N-1:N];
    assign w_change   = (w_dividend != r_a_q) || (w_divisor != r_b_q);

    // Switch sampling and change detection; load comes out of reset high so the
    // first edge after release starts a division on whatever the switches show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q  <= '0;
            r_b_q  <= '0;
            r_load <= 1'b1;
        end else begin
            r_a_q  <= w_dividend;
            r_b_q  <= w_divisor;
            r_load <= w_change;
        end
    end

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        w_shift = {r_rem[N-1:0], r_quo[N-1]};
        w_trial = w_shift - {1'b0, r_d};
        if (!w_trial[N]) begin
            w_rem_step = w_trial;
            w_quo_step = {r_quo[N-2:0], 1'b1};
        end else begin
            w_rem_step = w_shift;
            w_quo_step = {r_quo[N-2:0], 1'b0};
        end
    end

    // Next-state and datapath control; a pending load overrides everything.
    always_comb begin
        w_state_nx  = r_state;
        w_d_nx      = r_d;
        w_quo_nx    = r_quo;
        w_rem_nx    = r_rem;
        w_cnt_nx    = r_cnt;
        w_result_nx = r_result;
        w_busy_nx   = r_busy;
        w_dz_nx     = r_dz;

        if (r_load) begin
            if (w_divisor != '0) begin
                w_d_nx     = w_divisor;
                w_quo_nx   = w_dividend;
                w_rem_nx   = '0;
                w_cnt_nx   = CW'(N);
                w_state_nx = S_RUN;
                w_busy_nx  = 1'b1;
            end else begin
                // Divide by zero resolves immediately: quotient saturates, remainder is the dividend.
                w_result_nx = {w_dividend, {N{1'b1}}};
                w_dz_nx     = 1'b1;
                w_state_nx  = S_IDLE;
                w_busy_nx   = 1'b0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    w_quo_nx = w_quo_step;
                    w_rem_nx = w_rem_step;
                    w_cnt_nx = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_result_nx = {w_rem_step[N-1:0], w_quo_step};
                        w_dz_nx     = 1'b0;
                        w_busy_nx   = 1'b0;
                        w_state_nx  = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_d      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_d      <= w_d_nx;
            r_quo    <= w_quo_nx;
            r_rem    <= w_rem_nx;
            r_cnt    <= w_cnt_nx;
            r_result <= w_result_nx;
            r_busy   <= w_busy_nx;
            r_dz     <= w_dz_nx;
        end
    end

    // Active-low LED boards get a static inversion of the held result only.
    assign led  = INV ? ~r_result : r_result;
    assign busy = r_busy;
    assign dz   = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider (N=8, one INV=0 and one INV=1 instance).
`timescale 1ns/1ps
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic [15:0] led;
    logic        busy;
    logic        dz;
    logic [15:0] sw2;
    logic [15:0] led2;
    logic        busy2;
    logic        dz2;

    int n_checks;
    int n_errors;

    seq_divider #(.N(8), .INV(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led(led), .busy(busy), .dz(dz)
    );

    seq_divider #(.N(8), .INV(1'b1)) u_dut_inv (
        .clk(clk), .rst_n(rst_n), .sw(sw2), .led(led2), .busy(busy2), .dz(dz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Waits for a launched division to finish; saw_busy reports busy at the capture point.
    task automatic wait_done(input bit inv_inst, output bit timeout, output bit saw_busy);
        repeat (2) @(negedge clk);
        saw_busy = inv_inst ? busy2 : busy;
        timeout  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!(inv_inst ? busy2 : busy)) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit to, sb;
        rst_n = 1'b0;
        sw    = {8'h07, 8'h64};
        sw2   = {8'h07, 8'h64};
        #3;
        n_checks++;
        if (led !== 16'h0000 || busy !== 1'b0 || dz !== 1'b0) begin
            $display("FAIL reset_state: led=%h busy=%b dz=%b, want led=0000 busy=0 dz=0", led, busy, dz);
            n_errors++;
        end
        n_checks++;
        if (led2 !== 16'hFFFF || busy2 !== 1'b0 || dz2 !== 1'b0) begin
            $display("FAIL reset_state_inv: led=%h busy=%b dz=%b, want led=FFFF busy=0 dz=0", led2, busy2, dz2);
            n_errors++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || !sb) begin
            $display("FAIL reset_run: timeout=%b saw_busy=%b, want timeout=0 saw_busy=1", to, sb);
            n_errors++;
        end
        n_checks++;
        if (led !== 16'h020E || dz !== 1'b0) begin
            $display("FAIL div_100_7: led=%h dz=%b, want led=020E dz=0", led, dz);
            n_errors++;
        end
    endtask

    task automatic test_basic;
        bit to, sb;
        sw = {8'h01, 8'hFF};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h00FF || dz !== 1'b0) begin
            $display("FAIL div_FF_1: timeout=%b led=%h dz=%b, want led=00FF dz=0", to, led, dz);
            n_errors++;
        end
        sw = {8'hFF, 8'hFF};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h0001 || dz !== 1'b0) begin
            $display("FAIL div_FF_FF: timeout=%b led=%h dz=%b, want led=0001 dz=0", to, led, dz);
            n_errors++;
        end
    endtask

    task automatic test_div_zero;
        bit to, sb;
        sw = {8'h00, 8'h5A};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (sb !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL dz_no_busy: saw_busy=%b busy=%b, want 0", sb, busy);
            n_errors++;
        end
        n_checks++;
        if (led !== 16'h5AFF || dz !== 1'b1) begin
            $display("FAIL dz_result: led=%h dz=%b, want led=5AFF dz=1", led, dz);
            n_errors++;
        end
        sw = {8'h03, 8'h5A};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h001E || dz !== 1'b0) begin
            $display("FAIL dz_clear: timeout=%b led=%h dz=%b, want led=001E dz=0", to, led, dz);
            n_errors++;
        end
    endtask

    task automatic test_abort;
        bit to, sb;
        bit done;
        sw = {8'h07, 8'h64};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h020E) begin
            $display("FAIL abort_setup: timeout=%b led=%h, want led=020E", to, led);
            n_errors++;
        end
        sw = {8'h10, 8'hC8};
        repeat (2) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || led !== 16'h020E) begin
            $display("FAIL abort_midrun: busy=%b led=%h, want busy=1 led=020E", busy, led);
            n_errors++;
        end
        sw = {8'h09, 8'h05};
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n_checks++;
            if (led !== 16'h020E) begin
                $display("FAIL abort_hold: cycle %0d led=%h, want 020E", i, led);
                n_errors++;
            end
        end
        n_checks++;
        if (!done || led !== 16'h0500 || dz !== 1'b0) begin
            $display("FAIL abort_result: done=%b led=%h dz=%b, want led=0500 dz=0", done, led, dz);
            n_errors++;
        end
        sw = {8'h10, 8'hC8};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h080C) begin
            $display("FAIL div_200_16: timeout=%b led=%h, want led=080C", to, led);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back;
        bit to, sb;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? {8'h07, 8'h64} : {8'h03, 8'h5A};
            @(negedge clk);
            n_checks++;
            if (led !== 16'h080C) begin
                $display("FAIL toggle_hold: cycle %0d led=%h, want 080C", i, led);
                n_errors++;
            end
        end
        sw = {8'h05, 8'h2F};
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || led !== 16'h0209) begin
            $display("FAIL toggle_settle: timeout=%b led=%h, want led=0209", to, led);
            n_errors++;
        end
    endtask

    task automatic test_reset_midrun;
        bit to, sb;
        sw = {8'h07, 8'h64};
        repeat (2) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 16'h0000 || busy !== 1'b0 || dz !== 1'b0) begin
            $display("FAIL reset_midrun: led=%h busy=%b dz=%b, want led=0000 busy=0 dz=0", led, busy, dz);
            n_errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(1'b0, to, sb);
        n_checks++;
        if (to || !sb || led !== 16'h020E) begin
            $display("FAIL reset_restart: timeout=%b saw_busy=%b led=%h, want led=020E", to, sb, led);
            n_errors++;
        end
    endtask

    task automatic test_inv_sweep;
        bit to, sb;
        int a, d, q, r;
        n_checks++;
        if (led2 !== 16'hFDF1 || dz2 !== 1'b0) begin
            $display("FAIL inv_100_7: led=%h dz=%b, want led=FDF1 dz=0", led2, dz2);
            n_errors++;
        end
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 255));
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            sw2 = {8'(d), 8'(a)};
            wait_done(1'b1, to, sb);
            q = int'(~led2[7:0]) & 255;
            r = int'(~led2[15:8]) & 255;
            n_checks++;
            if (to) begin
                $display("FAIL sweep_timeout: a=%0d d=%0d", a, d);
                n_errors++;
            end else if (d == 0) begin
                if (dz2 !== 1'b1 || q != 255 || r != a) begin
                    $display("FAIL sweep_dz: a=%0d d=0 got q=%0d r=%0d dz=%b, want q=255 r=%0d dz=1", a, q, r, dz2, a);
                    n_errors++;
                end
            end else if (dz2 !== 1'b0 || q * d + r != a || r >= d) begin
                $display("FAIL sweep_div: a=%0d d=%0d got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                         a, d, q, r, dz2, a / d, a % d);
                n_errors++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        sw       = '0;
        sw2      = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_inv_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
